alu_pipe: RTL and testbench

- Parametrised, registered successor to the single-cycle integer ALU; generic WIDTH, extended op set (XOR, SLTU, SLL/SRL/SRA), and a tag passthrough.
- Sits in the EX stage behind a valid/ready handshake with a one-deep result register.
- Shifts are either single-cycle (barrel) or iterative (1 bit per cycle), selected by parameter, so area-constrained builds can drop the barrel shifter.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_comb.sv | 65 ++++++
 rtl/alu_pipe.sv | 125 ++++++++++++
 tb/tb_alu_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: op codes, FSM encoding, log2 helper.
// Latency: not applicable (definitions only).
// Backpressure: not applicable.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Smallest r with 2**r >= v; sizes the shift-amount field.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational WIDTH-generic ALU datapath: op, a, b -> result and arithmetic flags.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             illegal
);

   localparam int SW = clog2(WIDTH);

   logic [SW-1:0] shamt;
   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] sub_sum;
   logic           add_ovf;
   logic           sub_ovf;
   logic           slt;

   assign shamt   = b[SW-1:0];
   assign add_sum = {1'b0, a} + {1'b0, b};
   // Subtraction as a + ~b + 1 so bit WIDTH is the "no borrow" flag.
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
   // Signed less-than: difference sign corrected by overflow.
   assign slt     = sub_sum[WIDTH-1] ^ sub_ovf;

   // Op decode; flags other than illegal only meaningful for ADD/SUB.
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      illegal  = 1'b0;
      case (op)
         OP_ADD: begin
            result   = add_sum[WIDTH-1:0];
            carry    = add_sum[WIDTH];
            overflow = add_ovf;
         end
         OP_SUB: begin
            result   = sub_sum[WIDTH-1:0];
            carry    = sub_sum[WIDTH];
            overflow = sub_ovf;
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = $signed(a) >>> shamt;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready handshake, tag passthrough and optional iterative shifter.
// Latency: 1 cycle, or shamt+2 cycles for shifts when ITER_SHIFT=1.
// Backpressure: one-deep result register; in_ready drops while a result is stalled or a shift iterates.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int TAG_W      = 5,
   parameter int ITER_SHIFT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] tag_out,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             illegal
);

   localparam int SW = clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [SW-1:0]    cnt;
   logic [3:0]       sop;
   logic [TAG_W-1:0] ptag;

   logic [WIDTH-1:0] c_res;
   logic             c_carry;
   logic             c_ovf;
   logic             c_ill;
   logic             accept;
   logic             is_shift;
   logic             go_iter;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op       (op),
      .a        (a),
      .b        (b),
      .result   (c_res),
      .carry    (c_carry),
      .overflow (c_ovf),
      .illegal  (c_ill)
   );

   assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
   assign out_valid = (state == ST_HOLD);
   assign accept    = in_valid && in_ready;
   assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   assign go_iter   = (ITER_SHIFT != 0) && is_shift;

   // FSM, iterative shifter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         work     <= '0;
         cnt      <= '0;
         sop      <= OP_ADD;
         ptag     <= '0;
         result   <= '0;
         tag_out  <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (accept) begin
                  if (go_iter) begin
                     work  <= a;
                     cnt   <= b[SW-1:0];
                     sop   <= op;
                     ptag  <= tag_in;
                     state <= ST_SHIFT;
                  end else begin
                     result   <= c_res;
                     tag_out  <= tag_in;
                     carry    <= c_carry;
                     overflow <= c_ovf;
                     illegal  <= c_ill;
                     zero     <= (c_res == '0);
                     negative <= c_res[WIDTH-1];
                     state    <= ST_HOLD;
                  end
               end else if ((state == ST_HOLD) && out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (cnt != '0) begin
                  case (sop)
                     OP_SLL:  work <= {work[WIDTH-2:0], 1'b0};
                     OP_SRL:  work <= {1'b0, work[WIDTH-1:1]};
                     default: work <= {work[WIDTH-1], work[WIDTH-1:1]};
                  endcase
                  cnt <= cnt - SW'(1);
               end else begin
                  result   <= work;
                  tag_out  <= ptag;
                  carry    <= 1'b0;
                  overflow <= 1'b0;
                  illegal  <= 1'b0;
                  zero     <= (work == '0);
                  negative <= work[WIDTH-1];
                  state    <= ST_HOLD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: barrel (u0) and iterative (u1) builds side by side.
// Latency: checks 1-cycle and shamt+2-cycle paths.
// Backpressure: checks stall stability and back-to-back streaming.
module tb_alu_pipe;
   import alu_pkg::*;

   typedef struct packed {
      logic        ov;
      logic        ir;
      logic [31:0] res;
      logic [4:0]  tag;
      logic        c;
      logic        v;
      logic        z;
      logic        n;
      logic        il;
   } obs_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        il;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [3:0]  op;
   logic [4:0]  tag_in;
   logic        iv0, iv1, or0, or1;
   logic        ir0, ir1, ov0, ov1;
   logic [31:0] res0, res1;
   logic [4:0]  tag0, tag1;
   logic        c0, c1, v0, v1, z0, z1, n0, n1, il0, il1;
   obs_t        obs0, obs1;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(32), .TAG_W(5), .ITER_SHIFT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .op(op),
      .tag_in(tag_in), .out_valid(ov0), .out_ready(or0), .result(res0), .tag_out(tag0),
      .carry(c0), .overflow(v0), .zero(z0), .negative(n0), .illegal(il0)
   );

   alu_pipe #(.WIDTH(32), .TAG_W(5), .ITER_SHIFT(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .op(op),
      .tag_in(tag_in), .out_valid(ov1), .out_ready(or1), .result(res1), .tag_out(tag1),
      .carry(c1), .overflow(v1), .zero(z1), .negative(n1), .illegal(il1)
   );

   assign obs0 = {ov0, ir0, res0, tag0, c0, v0, z0, n0, il0};
   assign obs1 = {ov1, ir1, res1, tag1, c1, v1, z1, n1, il1};

   function automatic obs_t obs(input int s);
      return (s != 0) ? obs1 : obs0;
   endfunction

   function automatic obs_t mk(input logic ov, input logic ir, input logic [31:0] r,
                               input logic [4:0] t, input logic c, input logic v, input logic il);
      return {ov, ir, r, t, c, v, (r == 32'h0), r[31], il};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_iv(input int s, input logic val);
      if (s != 0) iv1 = val; else iv0 = val;
   endtask

   task automatic run_vec(input int s, input int idx, input vec_t vv);
      int   k;
      int   exp_k;
      logic ir_hi;
      @(negedge clk);
      op = vv.op; a = vv.a; b = vv.b; tag_in = 5'(idx);
      set_iv(s, 1'b1);
      @(posedge clk); #1;
      set_iv(s, 1'b0);
      k = 0;
      ir_hi = 1'b0;
      while (!obs(s).ov && k < 100) begin
         if (obs(s).ir) ir_hi = 1'b1;
         @(posedge clk); #1;
         k++;
      end
      exp_k = 0;
      if (s != 0 && (vv.op == OP_SLL || vv.op == OP_SRL || vv.op == OP_SRA))
         exp_k = int'(vv.b[4:0]) + 1;
      chk($sformatf("latency u%0d v%0d", s, idx), 64'(k), 64'(exp_k));
      if (exp_k > 0) chk($sformatf("in_ready low u%0d v%0d", s, idx), 64'(ir_hi), 64'(0));
      chk($sformatf("outputs u%0d v%0d", s, idx), 64'(obs(s)),
          64'(mk(1'b1, 1'b1, vv.res, 5'(idx), vv.c, vv.v, vv.il)));
   endtask

   initial begin
      obs_t held;
      rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
      a = '0; b = '0; op = OP_ADD; tag_in = '0;

      tbl.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_OR,   32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{OP_SLL,  32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SLL,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SRA,  32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{OP_SRA,  32'h80000004, 32'h00000002, 32'hE0000001, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{4'hF,    32'h12345678, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{4'hA,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1});

      // Reset state before any clock edge.
      #1;
      chk("reset u0", 64'(obs0), 64'(mk(1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0) & ~44'h6));
      chk("reset u1", 64'(obs1), 64'(mk(1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0) & ~44'h6));
      @(negedge clk);
      rst = 1'b1;

      // Vector table on both builds.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < tbl.size(); i++) run_vec(s, i, tbl[i]);
         @(posedge clk); #1;
         chk($sformatf("drain u%0d", s), 64'(obs(s).ov), 64'(0));
      end

      // Backpressure: stall 4 cycles with a competing request, then stream.
      @(negedge clk);
      or0 = 1'b0; op = OP_ADD; a = 32'd10; b = 32'd20; tag_in = 5'd3; iv0 = 1'b1;
      @(posedge clk); #1;
      held = mk(1'b1, 1'b0, 32'd30, 5'd3, 1'b0, 1'b0, 1'b0);
      a = 32'd99; b = 32'd1; tag_in = 5'd7;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("stall c%0d", i), 64'(obs0), 64'(held));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         or0 = 1'b1; a = 32'(i); b = 32'd100; tag_in = 5'(i + 8);
         @(posedge clk); #1;
         chk($sformatf("stream %0d", i), 64'(obs0),
             64'(mk(1'b1, 1'b1, 32'(i + 100), 5'(i + 8), 1'b0, 1'b0, 1'b0)));
      end
      @(negedge clk);
      iv0 = 1'b0;
      @(posedge clk); #1;
      chk("stream drain", 64'(ov0), 64'(0));

      // Reset in the middle of an iterative shift.
      @(negedge clk);
      op = OP_SLL; a = 32'h1; b = 32'd20; tag_in = 5'd9; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("busy before reset", 64'({ir1, ov1}), 64'(0));
      rst = 1'b0;
      #1;
      chk("reset mid shift", 64'(obs1), 64'(44'h0 | (44'h1 << 42)));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("after reset", 64'({ir1, ov1}), 64'(2'b10));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
